// File: rtl/lcd1602_text_scroller.sv
// lcd1602_text_scroller: HD44780 8-bit-bus controller that inits the panel, paints a 32-char buffer and scrolls it
module lcd1602_text_scroller #(
    parameter int W_KEY           = 8,
    parameter int EN_PULSE_CYC    = 14,
    parameter int CMD_GAP_CYC     = 1_080,
    parameter int CLR_GAP_CYC     = 48_600,
    parameter int POWERUP_CYC     = 1_080_000,
    parameter int AUTO_PERIOD_CYC = 6_750_000
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic [W_KEY-1:0] key,
    input  logic             mode_auto,
    input  logic             text_we,
    input  logic [4:0]       text_addr,
    input  logic [7:0]       text_data,
    output logic             busy,
    output logic [7:0]       LCD_DATA,
    output logic             LCD_RW,
    output logic             LCD_RS,
    output logic             LCD_EN
);
    localparam int M1 = EN_PULSE_CYC > CMD_GAP_CYC ? EN_PULSE_CYC : CMD_GAP_CYC;
    localparam int M2 = CLR_GAP_CYC > POWERUP_CYC ? CLR_GAP_CYC : POWERUP_CYC;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
    localparam int AW = $clog2(AUTO_PERIOD_CYC + 1);

    typedef enum logic [2:0] {PWRUP, FUNC, DISP, ENTRY, CLR, PAINT, IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, GAP} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d, gap_last;
    logic [5:0]    idx_q, idx_d;
    logic [4:0]    bi;
    logic [7:0]    tbuf [32];
    logic [7:0]    sh_byte, data_d;
    logic          rs_d, en_d, start;
    logic [1:0]    k1, k2, kp, kclr;
    logic          ap, aclr, dirty, dclr, past_init;
    logic [AW-1:0] acnt;
    logic          unused_key;

    assign LCD_RW     = 1'b0;
    assign past_init  = state_q >= PAINT;
    assign unused_key = ^key;

    // Next-state and next-output logic: power-up wait, idle arbitration, and setup/pulse/gap sequencing
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        en_d     = LCD_EN;
        rs_d     = LCD_RS;
        data_d   = LCD_DATA;
        start    = 1'b0;
        sh_byte  = 8'h18;
        kclr     = 2'b00;
        aclr     = 1'b0;
        gap_last = (!LCD_RS && (LCD_DATA == 8'h01 || LCD_DATA == 8'h02)) ? CW'(CLR_GAP_CYC - 1) : CW'(CMD_GAP_CYC - 1);
        if (state_q == PWRUP) begin
            start   = cnt_q == CW'(POWERUP_CYC - 1);
            state_d = start ? FUNC : PWRUP;
            cnt_d   = cnt_q + 1'b1;
        end else if (state_q == IDLE) begin
            start   = dirty | (|kp) | ap;
            state_d = dirty ? PAINT : (start ? SHIFT : IDLE);
            idx_d   = 6'd0;
            sh_byte = (!kp[0] && kp[1]) ? 8'h1C : 8'h18;
            kclr    = {!dirty && !kp[0] && kp[1], !dirty && kp[0]};
            aclr    = !dirty && kp == 2'b00 && ap;
        end else if (phase_q == SETUP) begin
            phase_d = PULSE;
            cnt_d   = '0;
            en_d    = 1'b1;
        end else if (phase_q == PULSE) begin
            phase_d = (cnt_q == CW'(EN_PULSE_CYC - 1)) ? GAP : PULSE;
            en_d    = cnt_q != CW'(EN_PULSE_CYC - 1);
            cnt_d   = (cnt_q == CW'(EN_PULSE_CYC - 1)) ? '0 : cnt_q + 1'b1;
        end else if (cnt_q == gap_last) begin
            idx_d   = (state_q == PAINT) ? idx_q + 6'd1 : 6'd0;
            state_d = (state_q == SHIFT || (state_q == PAINT && idx_q == 6'd33)) ? IDLE :
                      (state_q == PAINT) ? PAINT : state_t'(state_q + 3'd1);
            start   = state_d != IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        dclr = start && state_d == PAINT && state_q != PAINT;
        bi   = 5'(idx_d - ((idx_d > 6'd17) ? 6'd2 : 6'd1));
        if (start) begin
            phase_d        = SETUP;
            cnt_d          = '0;
            en_d           = 1'b0;
            {rs_d, data_d} = (state_d == FUNC)  ? 9'h038 :
                             (state_d == DISP)  ? 9'h00C :
                             (state_d == ENTRY) ? 9'h006 :
                             (state_d == CLR)   ? 9'h001 :
                             (state_d == SHIFT) ? {1'b0, sh_byte} :
                             (idx_d == 6'd0)    ? 9'h080 :
                             (idx_d == 6'd17)   ? 9'h0C0 : {1'b1, tbuf[bi]};
        end
    end

    // FSM state, transaction counters and registered LCD pins; busy lags the state by one cycle
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= PWRUP;
            phase_q  <= SETUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
            busy     <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            LCD_EN   <= en_d;
            LCD_RS   <= rs_d;
            LCD_DATA <= data_d;
            busy     <= !(state_q == IDLE && !dirty && kp == 2'b00 && !ap);
        end
    end

    // Key edge detection, one-deep request flags, repaint flag and auto-scroll timer
    always_ff @(posedge iclk) begin
        if (irst) begin
            k1    <= 2'b00;
            k2    <= 2'b00;
            kp    <= 2'b00;
            dirty <= 1'b0;
            acnt  <= '0;
            ap    <= 1'b0;
        end else begin
            k1    <= key[1:0];
            k2    <= k1;
            kp    <= (kp | (k1 & ~k2)) & ~kclr;
            dirty <= text_we | (dirty & ~dclr);
            if (!mode_auto) begin
                acnt <= '0;
                ap   <= 1'b0;
            end else begin
                if (past_init) acnt <= (acnt == AW'(AUTO_PERIOD_CYC - 1)) ? '0 : acnt + 1'b1;
                ap <= (ap & ~aclr) | (past_init && acnt == AW'(AUTO_PERIOD_CYC - 1));
            end
        end
    end

    // Text buffer: cleared to spaces on reset, written by the producer at any other time
    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < 32; i++) tbuf[i] <= 8'h20;
        end else if (text_we) begin
            tbuf[text_addr] <= text_data;
        end
    end
endmodule

// File: tb/tb_lcd1602_text_scroller.sv
// tb_lcd1602_text_scroller: scoreboard bench comparing every LCD write against a text/command reference model
module tb_lcd1602_text_scroller;
    localparam int EP = 2, CG = 4, XG = 8, PU = 10, AP = 50;

    logic       iclk = 1'b0, irst = 1'b1, mode_auto = 1'b0, text_we = 1'b0;
    logic [7:0] key = 8'h00, text_data = 8'h00;
    logic [4:0] text_addr = 5'd0;
    logic       busy, LCD_RW, LCD_RS, LCD_EN;
    logic [7:0] LCD_DATA;

    typedef struct {logic rs; logic [7:0] data; int lowc;} exp_t;
    exp_t       q[$];
    exp_t       cur;
    logic [7:0] mbuf [32];
    int         rise_t[$];
    int         vectors = 0, miscompares = 0, cyc = 0, lowcnt = 0, hicnt = 0, last_fall = 0;
    logic       in_txn = 1'b0, prev_busy = 1'b1;
    logic [4:0] wa [3];
    logic [7:0] wd [3];

    lcd1602_text_scroller #(
        .W_KEY(8), .EN_PULSE_CYC(EP), .CMD_GAP_CYC(CG), .CLR_GAP_CYC(XG),
        .POWERUP_CYC(PU), .AUTO_PERIOD_CYC(AP)
    ) dut (
        .iclk(iclk), .irst(irst), .key(key), .mode_auto(mode_auto), .text_we(text_we),
        .text_addr(text_addr), .text_data(text_data), .busy(busy), .LCD_DATA(LCD_DATA),
        .LCD_RW(LCD_RW), .LCD_RS(LCD_RS), .LCD_EN(LCD_EN)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input int lowc);
        exp_t e;
        e.rs = rs;
        e.data = data;
        e.lowc = lowc;
        q.push_back(e);
    endtask

    task automatic push_paint(input int l0);
        int l;
        l = (l0 < 0) ? -1 : CG + 1;
        push(1'b0, 8'h80, l0);
        for (int i = 0; i < 32; i++) begin
            if (i == 16) push(1'b0, 8'hC0, l);
            push(1'b1, mbuf[i], l);
        end
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, PU + 1);
        push(1'b0, 8'h0C, CG + 1);
        push(1'b0, 8'h06, CG + 1);
        push(1'b0, 8'h01, CG + 1);
        push_paint(XG + 1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0 || busy || LCD_EN) && n < budget) begin
            step(1);
            n++;
        end
        chk("drain_timeout", int'(n >= budget), 0);
        step(3);
    endtask

    task automatic wait_en(input logic need_rs);
        int n;
        n = 0;
        while (!(LCD_EN && (LCD_RS || !need_rs)) && n < 300) begin
            step(1);
            n++;
        end
        chk("en_wait_timeout", int'(n >= 300), 0);
    endtask

    task automatic shift_write(input int kbit, input int nw);
        for (int i = 0; i < nw; i++) mbuf[wa[i]] = wd[i];
        push(1'b0, kbit == 0 ? 8'h18 : 8'h1C, -1);
        push_paint(-1);
        key = 8'(1 << kbit);
        step(2);
        key = 8'h00;
        wait_en(1'b0);
        for (int i = 0; i < nw; i++) begin
            text_we = 1'b1;
            text_addr = wa[i];
            text_data = wd[i];
            step(1);
        end
        text_we = 1'b0;
        drain(1000);
    endtask

    // Monitor: pops one expectation per EN strobe and checks byte, EN width, hold, lead gap and busy
    initial forever begin
        @(negedge iclk);
        cyc++;
        if (irst) begin
            in_txn = 1'b0;
            lowcnt = 0;
            hicnt = 0;
            prev_busy = 1'b1;
        end else begin
            if (LCD_EN) begin
                if (!in_txn) begin
                    rise_t.push_back(cyc);
                    chk("txn_expected", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        chk("lcd_byte", {LCD_RS, LCD_DATA}, {cur.rs, cur.data});
                        if (cur.lowc >= 0) chk("lead_gap", lowcnt, cur.lowc);
                    end else begin
                        cur.rs = LCD_RS;
                        cur.data = LCD_DATA;
                        cur.lowc = -1;
                    end
                    chk("busy_in_txn", busy, 1);
                    in_txn = 1'b1;
                    hicnt = 0;
                end
                hicnt++;
            end else begin
                if (in_txn) begin
                    chk("en_width", hicnt, EP);
                    chk("bus_hold", {LCD_RS, LCD_DATA}, {cur.rs, cur.data});
                    in_txn = 1'b0;
                    last_fall = cyc;
                    lowcnt = 0;
                end
                lowcnt++;
            end
            if (prev_busy && !busy) chk("busy_fall", cyc - last_fall, CG + 1);
            prev_busy = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        step(3);
        chk("rst_en", LCD_EN, 0);
        chk("rst_data", LCD_DATA, 0);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_busy", busy, 1);
        push_init();
        irst = 1'b0;
        drain(1000);
        // repaint after writes landing during a left shift
        wa[0] = 5'd0;  wd[0] = 8'h48;
        wa[1] = 5'd17; wd[1] = 8'h69;
        shift_write(0, 2);
        // single key pulse, then a long hold: one shift each
        push(1'b0, 8'h18, -1);
        key = 8'h01;
        step(2);
        key = 8'h00;
        drain(300);
        push(1'b0, 8'h18, -1);
        key = 8'h01;
        step(100);
        key = 8'h00;
        drain(300);
        // simultaneous edges, extra key1 edges while pending are dropped
        push(1'b0, 8'h18, -1);
        push(1'b0, 8'h1C, -1);
        key = 8'h03;
        step(2);
        key = 8'h01;
        step(1);
        key = 8'h03;
        step(1);
        key = 8'h01;
        step(1);
        key = 8'h03;
        step(1);
        key = 8'h00;
        drain(300);
        step(20);
        // randomized buffer traffic
        repeat (4) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) begin
                wa[i] = 5'($urandom_range(0, 31));
                wd[i] = 8'($urandom_range(32, 126));
            end
            if ($urandom_range(0, 1) == 1) begin
                shift_write($urandom_range(0, 1), n);
            end else begin
                mbuf[wa[0]] = wd[0];
                push_paint(-1);
                text_we = 1'b1;
                text_addr = wa[0];
                text_data = wd[0];
                step(1);
                text_we = 1'b0;
                drain(1000);
            end
            step($urandom_range(1, 20));
        end
        // auto scroll period
        s = rise_t.size();
        repeat (3) push(1'b0, 8'h18, -1);
        mode_auto = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            step(1);
            n++;
        end
        mode_auto = 1'b0;
        chk("auto_timeout", int'(n >= 400), 0);
        drain(300);
        step(120);
        chk("auto_shift_count", rise_t.size() - s, 3);
        if (rise_t.size() - s == 3) begin
            chk("auto_period_1", rise_t[s+1] - rise_t[s], AP);
            chk("auto_period_2", rise_t[s+2] - rise_t[s+1], AP);
        end
        // reset in the middle of a paint data strobe
        mbuf[3] = 8'h58;
        push_paint(-1);
        text_we = 1'b1;
        text_addr = 5'd3;
        text_data = 8'h58;
        step(1);
        text_we = 1'b0;
        wait_en(1'b1);
        irst = 1'b1;
        q.delete();
        step(1);
        chk("abort_en", LCD_EN, 0);
        chk("abort_data", LCD_DATA, 0);
        chk("abort_rs", LCD_RS, 0);
        chk("abort_busy", busy, 1);
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        push_init();
        step(1);
        irst = 1'b0;
        drain(1000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
